// File: rtl/tst_cmd_rx_pkg.sv
// rtl/tst_cmd_rx_pkg.sv - shared types and constants for the test-entry command receiver
package tst_pkg;

   localparam int FRAME_BITS = 8;

   typedef enum logic [2:0] {
      MODE_NONE   = 3'd0,
      MODE_SCAN   = 3'd1,
      MODE_ANALOG = 3'd2,
      MODE_BIST   = 3'd3
   } tst_mode_e;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_KEY    = 3'd1,
      RX_CMD    = 3'd2,
      RX_CHK    = 3'd3,
      RX_ACTIVE = 3'd4,
      RX_LOCK   = 3'd5
   } rx_state_e;

endpackage

// File: rtl/tst_cmd_rx_sync2_edge.sv
// rtl/tst_cmd_rx_sync2_edge.sv - 2-flop pad synchroniser with optional registered rise pulse
module sync2_edge #(
   parameter bit RISE_EN = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o,
   output logic rise_o
);

   logic [1:0] sync_q;
   logic       prev_q;
   logic       rise_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b00;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], d_i};
         prev_q <= sync_q[1];
         rise_q <= RISE_EN & sync_q[1] & ~prev_q;
      end
   end

   // Rise pulse is registered so a raw edge reaches the FSM three clocks later.
   assign q_o    = sync_q[1];
   assign rise_o = rise_q;

endmodule

// File: rtl/tst_cmd_rx.sv
// rtl/tst_cmd_rx.sv - tester-side key/command/check frame receiver; TSTRX_LOCKOUT_EN adds permanent lockout
module tst_cmd_rx
   import tst_pkg::*;
#(
   parameter logic [7:0]  KEY      = 8'hA5,
   parameter int unsigned TOUT_CYC = 1024,
   parameter int unsigned EXIT_CYC = 16,
   parameter int unsigned MAX_FAIL = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tst_i,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic [2:0] mode_o,
   output logic       mode_vld_o,
   output logic       frame_err_o,
   output logic       locked_o
);

   localparam int TW = $clog2(TOUT_CYC + 1);
   localparam int EW = $clog2(EXIT_CYC + 1);
   localparam int BW = $clog2(FRAME_BITS);

   logic tst_s, scl_rise, sda_s;
   logic unused_tst_rise, unused_sda_rise, unused_scl_lvl;

   sync2_edge #(.RISE_EN(1'b0)) u_sync_tst (
      .clk(clk), .rst(rst), .d_i(tst_i), .q_o(tst_s), .rise_o(unused_tst_rise));
   sync2_edge #(.RISE_EN(1'b1)) u_sync_scl (
      .clk(clk), .rst(rst), .d_i(scl_i), .q_o(unused_scl_lvl), .rise_o(scl_rise));
   sync2_edge #(.RISE_EN(1'b0)) u_sync_sda (
      .clk(clk), .rst(rst), .d_i(sda_i), .q_o(sda_s), .rise_o(unused_sda_rise));

   rx_state_e         state_q, state_d;
   tst_mode_e         mode_q, mode_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [TW-1:0]     tout_q, tout_d;
   logic [EW-1:0]     exit_q, exit_d;
   logic [7:0]        sr_q, sr_d;
   logic [7:0]        cmd_q, cmd_d;
   logic              err_q;
   logic              acc_w, rej_w, tout_err_w, perm_lock;
   logic [7:0]        byte_w;
   logic              last_bit, cmd_ok;

   assign byte_w   = {sr_q[FRAME_BITS-2:0], sda_s};
   assign last_bit = scl_rise && (bit_q == BW'(FRAME_BITS - 1));
   assign cmd_ok   = (cmd_q[7:3] == 5'd0) && (cmd_q[2:0] inside {3'd1, 3'd2, 3'd3});

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      bit_d      = bit_q;
      tout_d     = tout_q;
      exit_d     = exit_q;
      sr_d       = sr_q;
      cmd_d      = cmd_q;
      acc_w      = 1'b0;
      rej_w      = 1'b0;
      tout_err_w = 1'b0;
      case (state_q)
         RX_IDLE: begin
            bit_d  = '0;
            tout_d = '0;
            exit_d = '0;
            if (tst_s) state_d = RX_KEY;
         end
         RX_KEY, RX_CMD, RX_CHK: begin
            // TST loss beats everything; an scl_rise beats a coincident timeout.
            if (!tst_s) begin
               state_d = RX_IDLE;
            end else if (scl_rise) begin
               sr_d   = byte_w;
               bit_d  = bit_q + 1'b1;
               tout_d = '0;
               if (last_bit) begin
                  if (state_q == RX_KEY) begin
                     if (byte_w == KEY) state_d = RX_CMD;
                     else               rej_w   = 1'b1;
                  end else if (state_q == RX_CMD) begin
                     cmd_d   = byte_w;
                     state_d = RX_CHK;
                  end else if (cmd_ok && (byte_w == ~cmd_q)) begin
                     acc_w = 1'b1;
                  end else begin
                     rej_w = 1'b1;
                  end
               end
            end else if (tout_q == TW'(TOUT_CYC - 1)) begin
               tout_err_w = 1'b1;
               state_d    = RX_IDLE;
            end else begin
               tout_d = tout_q + 1'b1;
            end
         end
         RX_ACTIVE: begin
            if (tst_s) begin
               exit_d = '0;
            end else if (exit_q == EW'(EXIT_CYC - 1)) begin
               mode_d  = MODE_NONE;
               state_d = RX_IDLE;
            end else begin
               exit_d = exit_q + 1'b1;
            end
         end
         RX_LOCK: begin
            if (!tst_s && !perm_lock) state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
      if (acc_w) begin
         mode_d  = tst_mode_e'(cmd_q[2:0]);
         state_d = RX_ACTIVE;
      end
      if (rej_w) state_d = RX_LOCK;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RX_IDLE;
         mode_q  <= MODE_NONE;
         bit_q   <= '0;
         tout_q  <= '0;
         exit_q  <= '0;
         sr_q    <= '0;
         cmd_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         bit_q   <= bit_d;
         tout_q  <= tout_d;
         exit_q  <= exit_d;
         sr_q    <= sr_d;
         cmd_q   <= cmd_d;
         err_q   <= rej_w | tout_err_w;
      end
   end

`ifdef TSTRX_LOCKOUT_EN
   localparam int FW = ($clog2(MAX_FAIL + 1) > 2) ? $clog2(MAX_FAIL + 1) : 2;
   logic [FW-1:0] fail_q;

   // Only rejections count; timeouts are treated as a slow ATE, not an attack.
   always_ff @(posedge clk) begin
      if (rst)                            fail_q <= '0;
      else if (acc_w)                     fail_q <= '0;
      else if (rej_w && (fail_q != '1))   fail_q <= fail_q + 1'b1;
   end

   assign perm_lock = (fail_q >= FW'(MAX_FAIL));
`else
   logic unused_lockout;
   assign unused_lockout = acc_w ^ (MAX_FAIL == 0);
   assign perm_lock      = 1'b0;
`endif

   assign mode_o      = mode_q;
   assign mode_vld_o  = (mode_q != MODE_NONE);
   assign frame_err_o = err_q;
   assign locked_o    = (state_q == RX_LOCK);

endmodule

// File: tb/tb_tst_cmd_rx.sv
// tb/tb_tst_cmd_rx.sv - randomized self-checking bench for tst_cmd_rx
module tb_tst_cmd_rx;

   logic       clk = 1'b0;
   logic       rst, tst_i, scl_i, sda_i;
   logic [2:0] mode_o;
   logic       mode_vld_o, frame_err_o, locked_o;

   int n_tests = 0;
   int n_fail  = 0;
   int err_seen = 0;
   logic [2:0] mode_at3, mode_at4;

   always #5 clk = ~clk;

   tst_cmd_rx dut (
      .clk(clk), .rst(rst), .tst_i(tst_i), .scl_i(scl_i), .sda_i(sda_i),
      .mode_o(mode_o), .mode_vld_o(mode_vld_o), .frame_err_o(frame_err_o), .locked_o(locked_o));

   always @(negedge clk) if (frame_err_o === 1'b1) err_seen++;

   // Frame acceptance rule: right key, command 1..3 and check byte summing to 0xFF.
   function automatic int model_mode(input logic [7:0] k, input logic [7:0] c, input logic [7:0] x);
      if (k != 8'hA5) return 0;
      if (c < 8'd1 || c > 8'd3) return 0;
      if (int'(c) + int'(x) != 255) return 0;
      return int'(c);
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; tst_i = 1'b0; scl_i = 1'b0; sda_i = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic start_tst();
      tst_i = 1'b1;
      repeat (4) tick();
   endtask

   task automatic send_bit(input logic b, input int half, input bit last);
      scl_i = 1'b0; sda_i = b;
      repeat (half) tick();
      scl_i = 1'b1;
      if (last) begin
         repeat (3) tick();
         mode_at3 = mode_o;
         tick();
         mode_at4 = mode_o;
         repeat (half - 4) tick();
      end else begin
         repeat (half) tick();
      end
   endtask

   task automatic send_frame(input logic [7:0] k, input logic [7:0] c, input logic [7:0] x, input int half);
      logic [23:0] f;
      f = {k, c, x};
      for (int i = 23; i >= 0; i--) send_bit(f[i], half, i == 0);
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (mode_o !== 3'd0)      begin n_fail++; $display("FAIL reset_mode got %0d want 0", mode_o); end
      n_tests++; if (mode_vld_o !== 1'b0)  begin n_fail++; $display("FAIL reset_vld got %b want 0", mode_vld_o); end
      n_tests++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", frame_err_o); end
      n_tests++; if (locked_o !== 1'b0)    begin n_fail++; $display("FAIL reset_locked got %b want 0", locked_o); end
   endtask

   task automatic test_scan_frame();
      int e0;
      do_reset(); start_tst();
      e0 = err_seen;
      send_frame(8'hA5, 8'h01, 8'hFE, 10);
      n_tests++; if (mode_at3 !== 3'd0)   begin n_fail++; $display("FAIL scan_early got %0d want 0", mode_at3); end
      n_tests++; if (mode_at4 !== 3'd1)   begin n_fail++; $display("FAIL scan_latency got %0d want 1", mode_at4); end
      n_tests++; if (mode_vld_o !== 1'b1) begin n_fail++; $display("FAIL scan_vld got %b want 1", mode_vld_o); end
      n_tests++; if (locked_o !== 1'b0)   begin n_fail++; $display("FAIL scan_locked got %b want 0", locked_o); end
      n_tests++; if (err_seen != e0)      begin n_fail++; $display("FAIL scan_err got %0d want 0", err_seen - e0); end
   endtask

   task automatic test_bad_key();
      int e0;
      do_reset(); start_tst();
      e0 = err_seen;
      send_frame(8'h5A, 8'h01, 8'hFE, 10);
      n_tests++; if (err_seen - e0 != 1) begin n_fail++; $display("FAIL badkey_err pulses got %0d want 1", err_seen - e0); end
      n_tests++; if (locked_o !== 1'b1)  begin n_fail++; $display("FAIL badkey_locked got %b want 1", locked_o); end
      n_tests++; if (mode_o !== 3'd0)    begin n_fail++; $display("FAIL badkey_mode got %0d want 0", mode_o); end
      tst_i = 1'b0;
      repeat (4) tick();
      n_tests++; if (locked_o !== 1'b0)  begin n_fail++; $display("FAIL badkey_unlock got %b want 0", locked_o); end
      start_tst();
      send_frame(8'hA5, 8'h02, 8'hFD, 8);
      n_tests++; if (mode_o !== 3'd2)    begin n_fail++; $display("FAIL badkey_reentry got %0d want 2", mode_o); end
   endtask

   task automatic test_bad_frames();
      logic [7:0] cs [2] = '{8'h02, 8'h09};
      logic [7:0] xs [2] = '{8'hFF, 8'hF6};
      int e0;
      for (int i = 0; i < 2; i++) begin
         do_reset(); start_tst();
         e0 = err_seen;
         send_frame(8'hA5, cs[i], xs[i], 9);
         n_tests++; if (err_seen - e0 != 1) begin n_fail++; $display("FAIL badframe%0d_err got %0d want 1", i, err_seen - e0); end
         n_tests++; if (locked_o !== 1'b1)  begin n_fail++; $display("FAIL badframe%0d_locked got %b want 1", i, locked_o); end
         n_tests++; if (mode_o !== 3'd0)    begin n_fail++; $display("FAIL badframe%0d_mode got %0d want 0", i, mode_o); end
      end
   endtask

   task automatic test_exit();
      do_reset(); start_tst();
      send_frame(8'hA5, 8'h03, 8'hFC, 10);
      n_tests++; if (mode_o !== 3'd3) begin n_fail++; $display("FAIL exit_start got %0d want 3", mode_o); end
      tst_i = 1'b0; repeat (15) tick();
      tst_i = 1'b1; tick();
      tst_i = 1'b0; repeat (14) tick();
      n_tests++; if (mode_o !== 3'd3) begin n_fail++; $display("FAIL exit_held got %0d want 3", mode_o); end
      repeat (5) tick();
      n_tests++; if (mode_o !== 3'd0)     begin n_fail++; $display("FAIL exit_clear got %0d want 0", mode_o); end
      n_tests++; if (mode_vld_o !== 1'b0) begin n_fail++; $display("FAIL exit_vld got %b want 0", mode_vld_o); end
   endtask

   task automatic test_timeout();
      int e0, cnt;
      logic [12:0] bits;
      do_reset(); start_tst();
      e0 = err_seen;
      bits = {8'hA5, 5'b00000};
      for (int i = 12; i >= 0; i--) send_bit(bits[i], 10, 1'b0);
      cnt = 10;
      while (err_seen == e0 && cnt < 1200) begin tick(); cnt++; end
      n_tests++; if (cnt < 1024 || cnt > 1034) begin n_fail++; $display("FAIL timeout_delay got %0d want 1024..1034", cnt); end
      n_tests++; if (locked_o !== 1'b0) begin n_fail++; $display("FAIL timeout_locked got %b want 0", locked_o); end
      n_tests++; if (mode_o !== 3'd0)   begin n_fail++; $display("FAIL timeout_mode got %0d want 0", mode_o); end
      send_frame(8'hA5, 8'h01, 8'hFE, 6);
      n_tests++; if (mode_o !== 3'd1)   begin n_fail++; $display("FAIL timeout_recover got %0d want 1", mode_o); end
   endtask

   task automatic test_rst_mid();
      do_reset(); start_tst();
      send_frame(8'hA5, 8'h03, 8'hFC, 6);
      rst = 1'b1; tick(); rst = 1'b0;
      n_tests++; if (mode_o !== 3'd0 || mode_vld_o !== 1'b0)
         begin n_fail++; $display("FAIL rst_active got mode %0d vld %b want 0 0", mode_o, mode_vld_o); end
      repeat (4) tick();
      for (int i = 7; i >= 0; i--) send_bit(i[0], 6, 1'b0);
      n_tests++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_lock got %b want 1", locked_o); end
      rst = 1'b1; tick(); rst = 1'b0;
      n_tests++; if (locked_o !== 1'b0 || frame_err_o !== 1'b0)
         begin n_fail++; $display("FAIL rst_lock got locked %b err %b want 0 0", locked_o, frame_err_o); end
   endtask

   task automatic test_random();
      logic [7:0] k, c, x;
      int exp, e0, half;
      for (int n = 0; n < 12; n++) begin
         k = ($urandom % 2 == 0) ? 8'hA5 : 8'($urandom);
         c = ($urandom % 3 != 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
         x = ($urandom % 3 != 0) ? ~c : 8'($urandom);
         half = $urandom_range(5, 12);
         exp = model_mode(k, c, x);
         do_reset(); start_tst();
         e0 = err_seen;
         send_frame(k, c, x, half);
         n_tests++; if (mode_o !== 3'(exp))
            begin n_fail++; $display("FAIL rand%0d_mode k=%h c=%h x=%h got %0d want %0d", n, k, c, x, mode_o, exp); end
         n_tests++; if ((err_seen - e0) != ((exp == 0) ? 1 : 0) || locked_o !== (exp == 0))
            begin n_fail++; $display("FAIL rand%0d_reject got err %0d locked %b want %0d", n, err_seen - e0, locked_o, exp == 0); end
      end
   endtask

`ifdef TSTRX_LOCKOUT_EN
   task automatic test_lockout();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         start_tst();
         send_frame(8'h5A, 8'h01, 8'hFE, 6);
         tst_i = 1'b0;
         repeat (6) tick();
      end
      n_tests++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL lockout_hold got %b want 1", locked_o); end
      do_reset();
      n_tests++; if (locked_o !== 1'b0) begin n_fail++; $display("FAIL lockout_rst got %b want 0", locked_o); end
   endtask
`endif

   initial begin
      test_reset();
      test_scan_frame();
      test_bad_key();
      test_bad_frames();
      test_exit();
      test_timeout();
      test_rst_mid();
      test_random();
`ifdef TSTRX_LOCKOUT_EN
      test_lockout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
